// File: rtl/timing_ctrl_pkg.sv
// Shared encodings for the instruction timing controller: FSM state codes,
// common-bus source selects and the I/O opcode.
package timing_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_EXEC = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    localparam logic [2:0] OP_IO = 3'b111;

    // 3-to-8 one-hot opcode decode
    function automatic logic [7:0] onehot8(input logic [2:0] op);
        return 8'b1 << op;
    endfunction

endpackage

// File: rtl/timing_ctrl_reg.sv
// Generic register block: async active-high reset, sync clear,
// parallel load and increment (clear > load > increment).
module timing_ctrl_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    input  logic         inc,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // register update; increment wraps naturally modulo 2^W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end else if (inc) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/timing_ctrl.sv
// Instruction timing controller: fetch (T0-T2), optional indirect (T3),
// variable-length EXEC handshake, HALT, and a retired-instruction counter.
module timing_ctrl
    import timing_ctrl_pkg::*;
#(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          halt_req,
    input  logic [15:0]   ir,
    input  logic          exec_done,
    output logic [2:0]    bus_sel,
    output logic          ar_we,
    output logic          pc_inc,
    output logic          ir_we,
    output logic          mem_rd,
    output logic          exec_start,
    output logic [7:0]    d_op,
    output logic          i_bit,
    output logic [2:0]    t_state,
    output logic          halted,
    output logic [CW-1:0] instr_cnt
);

    state_t state;
    state_t state_next;
    logic   exec_first;
    logic   retire;
    logic   unused_ir_bits;

    assign unused_ir_bits = ^ir[11:0];

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // decode latch at T2 exit, and first-EXEC-cycle marker
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_op       <= 8'h00;
            i_bit      <= 1'b0;
            exec_first <= 1'b0;
        end else begin
            if (state == S_T2) begin
                i_bit <= ir[15];
                d_op  <= onehot8(ir[14:12]);
            end
            exec_first <= (state_next == S_EXEC) && (state != S_EXEC);
        end
    end

    // next-state and Moore strobes
    always_comb begin
        state_next = state;
        bus_sel    = BUS_NONE;
        ar_we      = 1'b0;
        pc_inc     = 1'b0;
        ir_we      = 1'b0;
        mem_rd     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_next = S_T0;
            end
            S_T0: begin
                bus_sel    = BUS_PC;
                ar_we      = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                mem_rd     = 1'b1;
                bus_sel    = BUS_MEM;
                ir_we      = 1'b1;
                pc_inc     = 1'b1;
                state_next = S_T2;
            end
            S_T2: begin
                bus_sel = BUS_IR;
                ar_we   = 1'b1;
                if (ir[15] && (ir[14:12] != OP_IO)) state_next = S_T3;
                else                                 state_next = S_EXEC;
            end
            S_T3: begin
                mem_rd     = 1'b1;
                bus_sel    = BUS_MEM;
                ar_we      = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) state_next = halt_req ? S_HALT : S_T0;
            end
            S_HALT: begin
                if (start && !halt_req) state_next = S_T0;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign retire     = (state == S_EXEC) && exec_done;
    assign exec_start = (state == S_EXEC) && exec_first;
    assign t_state    = state;
    assign halted     = (state == S_HALT);

    // clear is tied to the async reset path as well so a held reset keeps it zero
    timing_ctrl_reg #(
        .W(CW)
    ) u_instr_cnt (
        .clk (clk),
        .rst (~reset),
        .clr (~reset),
        .we  (1'b0),
        .inc (retire),
        .d   ('0),
        .q   (instr_cnt)
    );

endmodule

// File: tb/tb_timing_ctrl.sv
// Self-checking bench for timing_ctrl: directed vector table, hand-written
// reset/wrap sequences, and randomized instructions against a
// transaction-level model (expected state sequence per instruction).
module tb_timing_ctrl;
    import timing_ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          halt_req;
    logic [15:0]   ir;
    logic          exec_done;
    logic [2:0]    bus_sel;
    logic          ar_we;
    logic          pc_inc;
    logic          ir_we;
    logic          mem_rd;
    logic          exec_start;
    logic [7:0]    d_op;
    logic          i_bit;
    logic [2:0]    t_state;
    logic          halted;
    logic [CW-1:0] instr_cnt;

    int errors = 0;
    int checks = 0;

    // model state
    int         m_cnt = 0;
    logic [7:0] m_dop = 8'h00;
    logic       m_ib  = 1'b0;

    typedef struct {
        logic          s;
        logic          h;
        logic [15:0]   i;
        logic          d;
        state_t        st;
        logic          xs;
        logic [7:0]    dop;
        logic          ib;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t tbl[$];

    timing_ctrl #(.CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt_req   (halt_req),
        .ir         (ir),
        .exec_done  (exec_done),
        .bus_sel    (bus_sel),
        .ar_we      (ar_we),
        .pc_inc     (pc_inc),
        .ir_we      (ir_we),
        .mem_rd     (mem_rd),
        .exec_start (exec_start),
        .d_op       (d_op),
        .i_bit      (i_bit),
        .t_state    (t_state),
        .halted     (halted),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {bus_sel, ar_we, pc_inc, ir_we, mem_rd} as listed for each state
    function automatic logic [6:0] strobes_for(input state_t st);
        case (st)
            S_T0:    return {3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
            S_T1:    return {3'd7, 1'b0, 1'b1, 1'b1, 1'b1};
            S_T2:    return {3'd5, 1'b1, 1'b0, 1'b0, 1'b0};
            S_T3:    return {3'd7, 1'b1, 1'b0, 1'b0, 1'b1};
            default: return 7'd0;
        endcase
    endfunction

    task automatic check_out(input state_t st, input logic xs, input logic [7:0] dop,
                             input logic ib, input logic [CW-1:0] cnt);
        check("t_state", t_state, st);
        check("strobes", {bus_sel, ar_we, pc_inc, ir_we, mem_rd}, strobes_for(st));
        check("exec_start", exec_start, xs);
        check("halted", halted, st == S_HALT);
        check("d_op", d_op, dop);
        check("i_bit", i_bit, ib);
        check("instr_cnt", instr_cnt, cnt);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [15:0] rw();
        return 16'($urandom);
    endfunction

    task automatic add(input logic s, input logic h, input logic [15:0] i, input logic d,
                       input state_t st, input logic xs, input logic [7:0] dop,
                       input logic ib, input logic [CW-1:0] cnt);
        vec_t v;
        v.s = s; v.h = h; v.i = i; v.d = d;
        v.st = st; v.xs = xs; v.dop = dop; v.ib = ib; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    // one clock cycle: drive inputs, check outputs against model, advance
    task automatic cycle(input logic s, input logic h, input logic [15:0] i, input logic d,
                         input state_t st, input logic xs);
        start = s; halt_req = h; ir = i; exec_done = d;
        check_out(st, xs, m_dop, m_ib, CW'(m_cnt));
        @(posedge clk); #1;
    endtask

    // one instruction starting in T0; n = EXEC cycles; hlt = halt on retire
    task automatic run_instr(input logic [15:0] instr, input int unsigned n, input logic hlt);
        logic ind;
        int   w;
        ind = instr[15] && (instr[14:12] != 3'b111);
        cycle(rb(), rb(), rw(), rb(), S_T0, 1'b0);
        cycle(rb(), rb(), rw(), rb(), S_T1, 1'b0);
        cycle(rb(), rb(), instr, rb(), S_T2, 1'b0);
        m_ib  = instr[15];
        m_dop = 8'(2 ** int'(instr[14:12]));
        if (ind) cycle(rb(), rb(), rw(), rb(), S_T3, 1'b0);
        for (int unsigned k = 0; k < n; k++) begin
            cycle(rb(), (k == n - 1) ? hlt : rb(), rw(), (k == n - 1), S_EXEC, (k == 0));
        end
        m_cnt = (m_cnt + 1) % (1 << CW);
        if (hlt) begin
            w = $urandom_range(0, 3);
            for (int j = 0; j < w; j++) cycle(rb(), 1'b1, rw(), rb(), S_HALT, 1'b0);
            cycle(1'b1, 1'b0, rw(), rb(), S_HALT, 1'b0);
        end
    endtask

    initial begin
        // directed vectors: direct, indirect, opcode 7 with stall, halt
        add(0, 1, 16'h0000, 1, S_IDLE, 0, 8'h00, 0, 0);
        add(1, 0, 16'h2005, 0, S_IDLE, 0, 8'h00, 0, 0);
        add(0, 1, 16'h2005, 0, S_T0,   0, 8'h00, 0, 0);
        add(1, 0, 16'h2005, 0, S_T1,   0, 8'h00, 0, 0);
        add(0, 0, 16'h2005, 0, S_T2,   0, 8'h00, 0, 0);
        add(0, 0, 16'h2005, 1, S_EXEC, 1, 8'h04, 0, 0);
        add(0, 0, 16'hA005, 0, S_T0,   0, 8'h04, 0, 1);
        add(0, 0, 16'hA005, 0, S_T1,   0, 8'h04, 0, 1);
        add(0, 0, 16'hA005, 0, S_T2,   0, 8'h04, 0, 1);
        add(0, 0, 16'hA005, 0, S_T3,   0, 8'h04, 1, 1);
        add(0, 0, 16'hA005, 0, S_EXEC, 1, 8'h04, 1, 1);
        add(0, 0, 16'hA005, 1, S_EXEC, 0, 8'h04, 1, 1);
        add(0, 0, 16'hF001, 0, S_T0,   0, 8'h04, 1, 2);
        add(0, 0, 16'hF001, 0, S_T1,   0, 8'h04, 1, 2);
        add(0, 0, 16'hF001, 0, S_T2,   0, 8'h04, 1, 2);
        add(0, 1, 16'hF001, 0, S_EXEC, 1, 8'h80, 1, 2);
        add(1, 1, 16'hF001, 0, S_EXEC, 0, 8'h80, 1, 2);
        add(0, 0, 16'hF001, 0, S_EXEC, 0, 8'h80, 1, 2);
        add(0, 1, 16'hF001, 0, S_EXEC, 0, 8'h80, 1, 2);
        add(0, 0, 16'hF001, 0, S_EXEC, 0, 8'h80, 1, 2);
        add(0, 1, 16'hF001, 1, S_EXEC, 0, 8'h80, 1, 2);
        add(0, 0, 16'h0000, 0, S_HALT, 0, 8'h80, 1, 3);
        add(1, 1, 16'h0000, 0, S_HALT, 0, 8'h80, 1, 3);
        add(1, 0, 16'h0000, 0, S_HALT, 0, 8'h80, 1, 3);
        add(0, 0, 16'h0000, 0, S_T0,   0, 8'h80, 1, 3);

        reset = 1'b0; start = 1'b0; halt_req = 1'b0; ir = '0; exec_done = 1'b0;
        #3;
        check_out(S_IDLE, 1'b0, 8'h00, 1'b0, '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].s; halt_req = tbl[i].h; ir = tbl[i].i; exec_done = tbl[i].d;
            check_out(tbl[i].st, tbl[i].xs, tbl[i].dop, tbl[i].ib, tbl[i].cnt);
            @(posedge clk); #1;
        end

        // now in T1: asynchronous reset must abort without a clock edge
        check("t1_ir_we", ir_we, 1'b1);
        #2 reset = 1'b0;
        #1;
        m_cnt = 0; m_dop = 8'h00; m_ib = 1'b0;
        check_out(S_IDLE, 1'b0, 8'h00, 1'b0, '0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        cycle(1'b0, rb(), rw(), rb(), S_IDLE, 1'b0);
        cycle(1'b0, rb(), rw(), rb(), S_IDLE, 1'b0);
        cycle(1'b1, 1'b0, rw(), 1'b0, S_IDLE, 1'b0);

        // sixteen retirements wrap the 4-bit counter 15 -> 0
        for (int k = 0; k < 16; k++) run_instr(rw(), 1, 1'b0);
        check("wrap", instr_cnt, 0);

        // randomized instructions
        for (int k = 0; k < 60; k++) begin
            run_instr(rw(), $urandom_range(1, 4), ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
